// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and default sizing for the UART receive sequencer
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for one asynchronous bit, reset value selectable
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_sequencer.sv
// rtl/uart_rx_sequencer.sv - oversampled UART frame sequencer: strobes shift/parity/stop capture
// and holds per-frame status until the consumer acknowledges it
module uart_rx_sequencer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int PARITY_EN  = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic sample_tick,
   input  logic rx_in,
   input  logic parity_error,
   input  logic frame_ack,
   output logic shift,
   output logic parity_load,
   output logic check_stop,
   output logic frame_valid,
   output logic parity_fail,
   output logic framing_err,
   output logic overrun,
   output logic busy
);

   localparam int OSW = $clog2(OVERSAMPLE);
   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

   uart_state_t    state, state_nxt;
   logic [OSW-1:0] os_cnt, os_nxt;
   logic [BCW-1:0] bit_cnt, bit_nxt;
   logic           rx_s;
   logic           complete;
   logic           par_arm;
   logic           par_pend;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx_in),
      .q     (rx_s)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         os_cnt  <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         os_cnt  <= os_nxt;
         bit_cnt <= bit_nxt;
      end
   end

   // After START the counter free-runs modulo OVERSAMPLE, so OS_LAST marks every mid-bit
   always_comb begin
      state_nxt   = state;
      os_nxt      = os_cnt;
      bit_nxt     = bit_cnt;
      shift       = 1'b0;
      parity_load = 1'b0;
      check_stop  = 1'b0;
      complete    = 1'b0;
      if (sample_tick) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_nxt = START;
                  os_nxt    = '0;
               end
            end
            START: begin
               if (os_cnt == OS_MID) begin
                  os_nxt    = '0;
                  bit_nxt   = '0;
                  state_nxt = rx_s ? IDLE : DATA;
               end else begin
                  os_nxt = os_cnt + 1'b1;
               end
            end
            DATA: begin
               os_nxt = os_cnt + 1'b1;
               if (os_cnt == OS_LAST) begin
                  shift   = 1'b1;
                  bit_nxt = bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) begin
                     state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                  end
               end
            end
            PARITY: begin
               os_nxt = os_cnt + 1'b1;
               if (os_cnt == OS_LAST) begin
                  parity_load = 1'b1;
                  state_nxt   = STOP;
               end
            end
            STOP: begin
               os_nxt = os_cnt + 1'b1;
               if (os_cnt == OS_LAST) begin
                  check_stop = 1'b1;
                  complete   = 1'b1;
                  state_nxt  = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // The checker answers one clk after parity_load; STOP's mid-bit is many ticks away, so the
   // late latch never collides with completion
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         par_arm     <= 1'b0;
         par_pend    <= 1'b0;
         frame_valid <= 1'b0;
         parity_fail <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         par_arm <= parity_load;
         if (par_arm) begin
            par_pend <= parity_error;
         end else if (complete) begin
            par_pend <= 1'b0;
         end
         if (complete) begin
            frame_valid <= 1'b1;
            parity_fail <= par_pend;
            framing_err <= ~rx_s;
            if (frame_valid && !frame_ack) begin
               overrun <= 1'b1;
            end
         end else if (frame_valid && frame_ack) begin
            frame_valid <= 1'b0;
            parity_fail <= 1'b0;
            framing_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// tb/tb_uart_rx_sequencer.sv - randomized scoreboard bench for uart_rx_sequencer
module tb_uart_rx_sequencer;

   localparam int OS = 16;

   typedef struct {
      int d;
      int nsh;
      int npl;
      int gap;
      bit pf;
      bit fe;
      bit ov;
   } exp_t;

   logic clk = 1'b0;
   logic reset, rx_in, parity_error;
   logic tick_a = 1'b0;
   logic tick_b = 1'b0;
   logic [1:0] ack;
   logic shift_a, pl_a, cs_a, fv_a, pf_a, fe_a, ov_a, busy_a;
   logic shift_b, pl_b, cs_b, fv_b, pf_b, fe_b, ov_b, busy_b;
   logic [1:0] sh, pl, cs, fv, pf, fe, ov, bz, tk;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   en_a = 1'b0;
   bit   en_b = 1'b0;
   bit   cur_err = 1'b0;
   bit   [1:0] ack_at_done = 2'b00;
   int   ack_req[2];
   int   ack_done[2];
   bit   m_fv[2];
   bit   m_ov[2];
   exp_t q[$];
   exp_t e;
   int   nsh[2], npl[2], tcnt[2], last[2], gap[2];
   bit   dpend[2];
   bit   pl_prev;

   always #5 clk = ~clk;

   uart_rx_sequencer dut_a (
      .clk(clk), .reset(reset), .sample_tick(tick_a), .rx_in(rx_in),
      .parity_error(parity_error), .frame_ack(ack[0]), .shift(shift_a),
      .parity_load(pl_a), .check_stop(cs_a), .frame_valid(fv_a), .parity_fail(pf_a),
      .framing_err(fe_a), .overrun(ov_a), .busy(busy_a)
   );

   uart_rx_sequencer #(.OVERSAMPLE(16), .DATA_BITS(7), .PARITY_EN(0)) dut_b (
      .clk(clk), .reset(reset), .sample_tick(tick_b), .rx_in(rx_in),
      .parity_error(parity_error), .frame_ack(ack[1]), .shift(shift_b),
      .parity_load(pl_b), .check_stop(cs_b), .frame_valid(fv_b), .parity_fail(pf_b),
      .framing_err(fe_b), .overrun(ov_b), .busy(busy_b)
   );

   assign sh = {shift_b, shift_a};
   assign pl = {pl_b, pl_a};
   assign cs = {cs_b, cs_a};
   assign fv = {fv_b, fv_a};
   assign pf = {pf_b, pf_a};
   assign fe = {fe_b, fe_a};
   assign ov = {ov_b, ov_a};
   assign bz = {busy_b, busy_a};
   assign tk = {tick_b, tick_a};

   task automatic chk(input string name, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      tick_a = en_a;
      tick_b = en_b && (cyc % 3 == 0);
   end

   // Monitor: tick-distance checks, parity checker model, acknowledge driver, scoreboard pop
   always @(negedge clk) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            nsh[d] = 0; npl[d] = 0; tcnt[d] = 0; last[d] = 0; dpend[d] = 1'b0;
         end
         pl_prev = 1'b0;
         ack = 2'b00;
         parity_error = 1'b1;
      end else begin
         parity_error = pl_prev ? cur_err : ~cur_err;
         pl_prev = |pl;
         for (int d = 0; d < 2; d++) begin
            if (dpend[d]) begin
               dpend[d] = 1'b0;
               chk($sformatf("frame_expected[%0d]", d), int'(q.size() > 0), 1);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  chk($sformatf("frame_dut[%0d]", d), e.d, d);
                  chk($sformatf("frame_valid[%0d]", d), int'(fv[d]), 1);
                  chk($sformatf("parity_fail[%0d]", d), int'(pf[d]), int'(e.pf));
                  chk($sformatf("framing_err[%0d]", d), int'(fe[d]), int'(e.fe));
                  chk($sformatf("overrun[%0d]", d), int'(ov[d]), int'(e.ov));
                  chk($sformatf("shift_count[%0d]", d), nsh[d], e.nsh);
                  chk($sformatf("parity_load_count[%0d]", d), npl[d], e.npl);
                  chk($sformatf("stop_gap[%0d]", d), gap[d], e.gap);
               end
               nsh[d] = 0;
               npl[d] = 0;
            end
            if (tk[d]) tcnt[d]++;
            if (sh[d] || pl[d] || cs[d]) begin
               chk($sformatf("pulse_excl[%0d]", d), int'(sh[d]) + int'(pl[d]) + int'(cs[d]), 1);
               chk($sformatf("pulse_busy[%0d]", d), int'(bz[d]), 1);
            end
            if (sh[d]) begin
               if (nsh[d] > 0) chk($sformatf("shift_gap[%0d]", d), tcnt[d] - last[d], OS);
               last[d] = tcnt[d];
               nsh[d]++;
            end
            if (pl[d]) begin
               chk($sformatf("parity_gap[%0d]", d), tcnt[d] - last[d], OS);
               npl[d]++;
            end
            if (cs[d]) begin
               gap[d] = tcnt[d] - last[d];
               dpend[d] = 1'b1;
            end
            if (cs[d] && ack_at_done[d]) begin
               ack[d] = 1'b1;
            end else if (ack_req[d] != ack_done[d]) begin
               ack[d] = 1'b1;
               ack_done[d]++;
            end else begin
               ack[d] = 1'b0;
            end
         end
      end
   end

   // Reference: a frame yields DATA_BITS shifts, one parity strobe if enabled, stop strobe one
   // bit after the last data/parity bit; overrun if a frame lands on an unacknowledged one
   task automatic send_frame(input int d, input int data, input bit bad, input bit stop_v,
                             input bit ack_cmp);
      exp_t x;
      int   p, nb, pe;
      bit   par;
      p  = (d == 0) ? 1 : 3;
      nb = (d == 0) ? 8 : 7;
      pe = (d == 0) ? 1 : 0;
      x.d   = d;
      x.nsh = nb;
      x.npl = pe;
      x.gap = OS * (1 + pe);
      x.pf  = (pe == 1) && bad;
      x.fe  = !stop_v;
      if (m_fv[d] && !ack_cmp) m_ov[d] = 1'b1;
      x.ov = m_ov[d];
      m_fv[d] = 1'b1;
      q.push_back(x);
      cur_err = bad;
      ack_at_done[d] = ack_cmp;
      par = bad;
      rx_in = 1'b0;
      step(OS * p);
      for (int i = 0; i < nb; i++) begin
         rx_in = data[i];
         par ^= data[i];
         step(OS * p);
      end
      if (pe == 1) begin
         rx_in = par;
         step(OS * p);
      end
      rx_in = stop_v;
      if (stop_v) begin
         step(OS * p);
      end else begin
         step(12 * p);
         rx_in = 1'b1;
         step(4 * p);
      end
      rx_in = 1'b1;
      step(2 * OS * p);
      ack_at_done[d] = 1'b0;
      cur_err = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q.size() != 0 || dpend[0] || dpend[1]) && n < 500) begin
         step(1);
         n++;
      end
      chk("drain_in_time", int'(n < 500), 1);
   endtask

   task automatic do_ack(input int d);
      ack_req[d]++;
      step(3);
      chk($sformatf("ack_clears[%0d]", d), int'(fv[d]), 0);
      m_fv[d] = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_shift[%0d]", tag, d), int'(sh[d]), 0);
         chk($sformatf("%s_parity_load[%0d]", tag, d), int'(pl[d]), 0);
         chk($sformatf("%s_check_stop[%0d]", tag, d), int'(cs[d]), 0);
         chk($sformatf("%s_frame_valid[%0d]", tag, d), int'(fv[d]), 0);
         chk($sformatf("%s_parity_fail[%0d]", tag, d), int'(pf[d]), 0);
         chk($sformatf("%s_framing_err[%0d]", tag, d), int'(fe[d]), 0);
         chk($sformatf("%s_overrun[%0d]", tag, d), int'(ov[d]), 0);
         chk($sformatf("%s_busy[%0d]", tag, d), int'(bz[d]), 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int data;
      for (int d = 0; d < 2; d++) begin
         ack_req[d] = 0; ack_done[d] = 0; m_fv[d] = 1'b0; m_ov[d] = 1'b0;
      end
      reset = 1'b0;
      rx_in = 1'b1;
      step(3);
      check_quiet("reset");
      reset = 1'b1;
      step(2);
      en_a = 1'b1;
      step(4);

      send_frame(0, 'h55, 1'b0, 1'b1, 1'b0);
      wait_drain();
      do_ack(0);

      rx_in = 1'b0;
      step(4);
      rx_in = 1'b1;
      step(1);
      chk("false_start_busy_high", int'(busy_a), 1);
      step(9);
      chk("false_start_busy_low", int'(busy_a), 0);
      chk("false_start_no_shift", nsh[0], 0);
      step(20);

      send_frame(0, int'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0);
      wait_drain();
      do_ack(0);

      send_frame(0, int'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
      wait_drain();
      do_ack(0);

      send_frame(0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      send_frame(0, int'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0);
      wait_drain();
      chk("overrun_sticky", int'(ov_a), 1);

      data = int'($urandom_range(0, 255));
      rx_in = 1'b0;
      step(OS);
      for (int i = 0; i < 3; i++) begin
         rx_in = data[i];
         step(OS);
      end
      rx_in = data[3];
      step(6);
      chk("shifts_before_reset", nsh[0], 3);
      reset = 1'b0;
      #1;
      check_quiet("midframe_reset");
      step(2);
      rx_in = 1'b1;
      step(1);
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         m_fv[d] = 1'b0; m_ov[d] = 1'b0;
      end
      step(3);

      send_frame(0, int'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0);
      wait_drain();
      send_frame(0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      wait_drain();
      chk("ack_at_completion_no_overrun", int'(ov_a), 0);
      do_ack(0);

      for (int k = 0; k < 3; k++) begin
         send_frame(0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0);
         wait_drain();
         do_ack(0);
      end

      en_a = 1'b0;
      en_b = 1'b1;
      step(6);
      for (int k = 0; k < 3; k++) begin
         send_frame(1, int'($urandom_range(0, 127)), 1'b0, 1'b1, 1'b0);
         wait_drain();
         do_ack(1);
      end

      chk("scoreboard_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_sequencer.md
UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

Interface
REQ-001 Parameter OVERSAMPLE, default 16, meaning sample_tick pulses per bit period (power of two, 8..16).
REQ-002 Parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-003 Parameter PARITY_EN, default 1, meaning a parity bit follows the data bits when set.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 sample_tick  in  1  one-clk enable at OVERSAMPLE x baud rate.
REQ-007 rx_in  in  1  raw serial line, idle high, asynchronous to clk.
REQ-008 parity_error  in  1  parity checker result, valid in the clk after parity_load.
REQ-009 frame_ack  in  1  consumer acknowledge of the current frame.
REQ-010 shift  out  1  one-clk pulse: shift register captures one data bit.
REQ-011 parity_load  out  1  one-clk pulse: parity checker captures the parity bit.
REQ-012 check_stop  out  1  one-clk pulse: stop bit is being sampled.
REQ-013 frame_valid  out  1  completed frame available; held until acknowledged.
REQ-014 parity_fail  out  1  parity failure of the held frame; valid while frame_valid=1.
REQ-015 framing_err  out  1  stop bit was 0 for the held frame; valid while frame_valid=1.
REQ-016 overrun  out  1  sticky: a frame completed while frame_valid was already 1.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 rx_in SHALL pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rx_s.
REQ-019 States SHALL be IDLE, START, DATA, PARITY, STOP; os_cnt (log2 OVERSAMPLE bits) advances only on sample_tick.
REQ-020 IDLE: on sample_tick with rx_s=0, go to START and clear os_cnt.
REQ-021 START: when os_cnt reaches OVERSAMPLE/2-1 on a tick, go to DATA with os_cnt and bit_cnt cleared if rx_s=0; otherwise go to IDLE (false start, no outputs).
REQ-022 DATA: on each tick with os_cnt=OVERSAMPLE-1 (mid-bit), pulse shift for exactly one clk and increment bit_cnt; os_cnt wraps to 0.
REQ-023 After the DATA_BITS-th shift, go to PARITY if PARITY_EN=1, else to STOP.
REQ-024 PARITY: at mid-bit, pulse parity_load one clk; on the following clk latch parity_error into a pending flag, then go to STOP.
REQ-025 STOP: at mid-bit, pulse check_stop one clk, latch framing flag = ~rx_s, complete the frame, go to IDLE.
REQ-026 Frame completion SHALL set frame_valid=1 and copy the pending parity and framing flags to parity_fail and framing_err.
REQ-027 A failed parity bit SHALL NOT abort the frame; the stop bit is always sampled.
REQ-028 frame_ack with frame_valid=1 SHALL clear frame_valid on the next clk; frame_ack with frame_valid=0 is ignored.
REQ-029 Completion while frame_valid=1 and no frame_ack SHALL set overrun and overwrite the flags; completion in the same clk as frame_ack SHALL leave frame_valid=1 and overrun unchanged.
REQ-030 overrun SHALL clear only on reset.
REQ-031 shift, parity_load and check_stop SHALL be mutually exclusive and never high outside DATA, PARITY or STOP respectively.
REQ-032 sample_tick=0 SHALL freeze os_cnt and the state; a tick held high on consecutive clks counts once per clk.

Reset
REQ-033 Asserting reset SHALL immediately force IDLE, os_cnt=0, bit_cnt=0, all pending flags=0, synchronizer=1, and every output=0, including mid-frame.
REQ-034 After deassertion, the first possible start detection SHALL be the first tick with rx_s=0.

Structure
REQ-035 A shared package uart_pkg SHALL hold the state encoding (IDLE=0 .. STOP=4, 3 bits) and the default OVERSAMPLE and DATA_BITS values.
REQ-036 The synchronizer SHALL be a separate sub-module uart_sync2 (1-bit, reset value parameterized); all other logic stays in this module.

Verification
REQ-037 Defaults, tick every clk, frame 0x55 with even parity correct and stop=1 -> 8 shift pulses 16 ticks apart, one parity_load, one check_stop, frame_valid=1, parity_fail=0, framing_err=0.
REQ-038 rx_in low for 4 ticks, then high -> return to IDLE, no shift, busy low by tick 8.
REQ-039 Frame with the parity bit inverted -> parity_fail=1, framing_err=0, check_stop still pulses once.
REQ-040 Frame with stop=0 -> framing_err=1; then two back-to-back frames without frame_ack -> overrun=1 after the second frame; frame_ack in the completion clk -> overrun stays 0.
REQ-041 Assert reset during the 4th data bit -> all outputs 0 at once; a clean frame after release is received correctly.
REQ-042 PARITY_EN=0, DATA_BITS=7, tick every 3rd clk -> 7 shift pulses, no parity_load, check_stop 16 ticks after the last shift.
